// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router port: tagged byte storage, occupancy flags,
// remaining-length tracking of the packet being read and a synchronous flush.
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    soft_rst,
    input  logic                    wr_en,
    input  logic                    lfd_state,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DATA_W-2:0]       pkt_rem,
    output logic                    pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [DATA_W-2:0] REM_ONE  = (DATA_W-1)'(1);

    // Bit DATA_W of each entry marks a packet header.
    logic [DATA_W:0]      mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [DATA_W-2:0]    pkt_rem_q, pkt_rem_d;
    logic                 pkt_done_q, pkt_done_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 lfd_q, lfd_d;

    logic                 wr_acc, rd_acc;
    logic [DATA_W:0]      rd_word;
    logic [DATA_W-2:0]    rd_len;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full = (count_q >= AF_LEVEL);
    assign wr_acc      = wr_en && !full;
    assign rd_acc      = rd_en && !empty;
    assign rd_word     = mem_q[rd_ptr_q[AW-1:0]];
    // Header length field excludes the parity byte, so one more byte remains to be read.
    assign rd_len      = {1'b0, rd_word[DATA_W-1:2]} + REM_ONE;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pkt_rem_d  = pkt_rem_q;
        pkt_done_d = 1'b0;
        data_out_d = data_out_q;
        lfd_d      = lfd_state;
        if (soft_rst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pkt_rem_d  = '0;
            data_out_d = '0;
            lfd_d      = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (wr_acc && !rd_acc)      count_d = count_q + PTR_ONE;
            else if (rd_acc && !wr_acc) count_d = count_q - PTR_ONE;
            if (rd_acc) begin
                data_out_d = rd_word[DATA_W-1:0];
                if (rd_word[DATA_W]) begin
                    pkt_rem_d = rd_len;
                end else if (pkt_rem_q != '0) begin
                    pkt_rem_d  = pkt_rem_q - REM_ONE;
                    pkt_done_d = (pkt_rem_q == REM_ONE);
                end
            end else if (pkt_rem_q == '0) begin
                data_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_rem_q  <= '0;
            pkt_done_q <= 1'b0;
            data_out_q <= '0;
            lfd_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_rem_q  <= pkt_rem_d;
            pkt_done_q <= pkt_done_d;
            data_out_q <= data_out_d;
            lfd_q      <= lfd_d;
        end
    end

    // Storage carries no reset; a flush only needs to block the write.
    always_ff @(posedge clk) begin
        if (wr_acc && !soft_rst) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
    end

    assign data_out = data_out_q;
    assign count    = count_q;
    assign pkt_rem  = pkt_rem_q;
    assign pkt_done = pkt_done_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: directed packet scenarios plus random traffic, checked by a
// queue-based reference model through an expectation scoreboard.
module tb_router_pkt_fifo;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AF_LVL = DEPTH - 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic soft_rst = 1'b0, wr_en = 1'b0, lfd_state = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic empty, full, almost_full, pkt_done;
    logic [4:0] count;
    logic [6:0] pkt_rem;

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(2)) dut (
        .clk(clk), .rstn(rstn), .soft_rst(soft_rst), .wr_en(wr_en),
        .lfd_state(lfd_state), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .empty(empty), .full(full), .almost_full(almost_full),
        .count(count), .pkt_rem(pkt_rem), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct { bit tag; int data; } ent_t;
    typedef struct { int dout; int cnt; int emp; int ful; int af; int rem; int done; } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    int   m_rem = 0, m_dout = 0, m_done = 0;
    bit   m_lfd = 1'b0;
    int   n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    endtask

    // Behavioural view: a queue of tagged bytes and a countdown of the packet being read.
    task automatic model_step(input bit s, input bit w, input bit l, input int d, input bit r);
        bit   was_full, was_empty;
        ent_t e;
        if (s) begin
            mq.delete();
            m_rem = 0; m_dout = 0; m_done = 0; m_lfd = 1'b0;
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_done = 0;
        if (r && !was_empty) begin
            e = mq.pop_front();
            m_dout = e.data;
            if (e.tag) m_rem = (e.data / 4) + 1;
            else if (m_rem > 0) begin
                if (m_rem == 1) m_done = 1;
                m_rem = m_rem - 1;
            end
        end else if (m_rem == 0) begin
            m_dout = 0;
        end
        if (w && !was_full) begin
            e.tag = m_lfd; e.data = d;
            mq.push_back(e);
        end
        m_lfd = l;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rem = 0; m_dout = 0; m_done = 0; m_lfd = 1'b0;
    endtask

    task automatic cycle(input bit s, input bit w, input bit l, input int d, input bit r);
        exp_t x;
        @(negedge clk);
        soft_rst = s; wr_en = w; lfd_state = l; data_in = DW'(d); rd_en = r;
        model_step(s, w, l, d, r);
        x.dout = m_dout; x.cnt = mq.size(); x.emp = (mq.size() == 0);
        x.ful = (mq.size() == DEPTH); x.af = (mq.size() >= AF_LVL);
        x.rem = m_rem; x.done = m_done;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"}, int'(data_out), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_rem"}, int'(pkt_rem), 0);
        chk({tag, "_done"}, int'(pkt_done), 0);
    endtask

    // Monitor: compares DUT outputs against the expectation queued for each edge.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("data_out", int'(data_out), x.dout);
            chk("count", int'(count), x.cnt);
            chk("empty", int'(empty), x.emp);
            chk("full", int'(full), x.ful);
            chk("almost_full", int'(almost_full), x.af);
            chk("pkt_rem", int'(pkt_rem), x.rem);
            chk("pkt_done", int'(pkt_done), x.done);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int hdr;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // Packet of length 3 read back end to end.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h0D, 0);
        cycle(0, 1, 0, 8'hA1, 0);
        cycle(0, 1, 0, 8'hA2, 0);
        cycle(0, 1, 0, 8'hA3, 0);
        cycle(0, 1, 0, 8'hFF, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
        idle(2);

        // Fill to full, overflow attempt, drain.
        for (int i = 0; i < 17; i++) cycle(0, 1, 0, int'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 1);
        idle(1);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 16 + i, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 100 + i, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1);
        idle(1);

        // Simultaneous read and write at count 5 and at full.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 40 + i, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 60 + i, 1);
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 80 + i, 0);
        cycle(0, 1, 0, 8'hEE, 1);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 1);
        idle(1);

        // Flush in the middle of a packet, with read and write also requested.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h08, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'hB0 + i, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 0, 8'h55, 1);
        idle(2);

        // Asynchronous reset between edges while a packet is being read.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h10, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'hC0 + i, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async");
        rstn = 1'b1;
        model_reset();
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'h77, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        idle(2);

        // Random traffic, write-heavy then read-heavy.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                bit s, w, l, r;
                s = ($urandom_range(0, 63) == 0);
                w = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                r = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                l = ($urandom_range(0, 7) == 0);
                hdr = int'($urandom_range(0, 255));
                cycle(s, w, l, hdr, r);
            end
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
